// File: rtl/alu_req_arbiter.sv
// Two-port round-robin front end for a shared combinational ALU: registers the
// winning operands onto the ALU, captures Result/Zero, and holds them until accepted.
module alu_req_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
  } op_t;

  state_t state, state_nxt;
  logic   last;
  logic   gnt0, gnt1;
  op_t    req0_pkt, req1_pkt, win_pkt;

  assign req0_pkt = {req0_a, req0_b, req0_op};
  assign req1_pkt = {req1_a, req1_b, req1_op};
  assign win_pkt  = gnt1 ? req1_pkt : req0_pkt;

  // last==1 means port 1 was served most recently, so port 0 wins a tie.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && (!req1_valid || last)) gnt0 = 1'b1;
        else if (req1_valid)                     gnt1 = 1'b1;
        if (gnt0 || gnt1) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = rst_n & gnt0;
  assign req1_ready = rst_n & gnt1;
  assign rsp_valid  = (state == RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt0 || gnt1) begin
        alu_a  <= win_pkt.a;
        alu_b  <= win_pkt.b;
        alu_op <= win_pkt.op;
        rsp_id <= gnt1;
        last   <= gnt1;
      end
      // ALU is combinational off the registered operands; sample it once in EXEC.
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
      end
    end
  end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Shares the single combinational ALU (operands `A`, `B`, 3-bit `ALU_operation`, outputs `Result`, `Zero`) between two requesters, e.g. the main execute path (port 0) and the address/branch unit (port 1). It arbitrates round-robin and registers the winning operands onto the ALU inputs. It captures `Result`/`Zero` one cycle later and holds them on a response channel until the owner accepts them. It sits between the requesters and the ALU instance in the CPU datapath. It is the only driver of the ALU inputs.

## Interface
- `WIDTH`, 32: operand/result width.
- `OPW`, 3: ALU opcode width. Opcodes pass through unmodified: 0 add, 4 sub, 1 and, 5 or, 2 xor, 6 B<<16.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req0_valid` in 1: port 0 has an operation pending.
- `req0_ready` out 1: port 0 accepted this cycle; transfer happens when `req0_valid & req0_ready`.
- `req0_a`, `req0_b` in WIDTH: port 0 operands.
- `req0_op` in OPW: port 0 opcode.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as port 0, for port 1.
- `alu_a`, `alu_b` out WIDTH: registered operands to ALU `A`/`B`.
- `alu_op` out OPW: registered opcode to ALU `ALU_operation`.
- `alu_result` in WIDTH: ALU `Result`.
- `alu_zero` in 1: ALU `Zero`.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: response consumer accepts.
- `rsp_id` out 1: port that issued the response (0/1).
- `rsp_result` out WIDTH: captured result.
- `rsp_zero` out 1: captured zero flag.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If neither valid is high: stay in IDLE.
  - Else compute a grant and assert the granted port's `reqN_ready` combinationally. `reqN_ready` depends on state, `reqN_valid` and the pointer only. It is never high outside IDLE and never high for both ports.
  - On accept: load `alu_a/alu_b/alu_op` from the granted port, latch grant into `rsp_id`, update the pointer, go to EXEC.
- Arbitration:
  - If only one port is valid, that port wins.
  - If both are valid, the port not served last wins.
  - Pointer `last` resets to 1, so port 0 wins the first tie after reset.
- EXEC: capture `alu_result` into `rsp_result` and `alu_zero` into `rsp_zero`, then go to RESP. `alu_*` hold their values.
- RESP:
  - `rsp_valid`=1. `rsp_id`, `rsp_result`, `rsp_zero` stay stable until the handshake.
  - On `rsp_ready`: go to IDLE.
  - No new request is accepted in RESP, including the handshake cycle.
- `alu_*` keep their last values in IDLE; they are not cleared.
- Requester rule: `reqN_a/b/op` must be stable while `reqN_valid` is high and not yet accepted. `reqN_valid` must not depend on `reqN_ready`. The arbiter never drops a valid request.
- Operand width rule: no extension or truncation. The ALU owns all arithmetic. Overflow wraps modulo 2^WIDTH inside the ALU.
- Reset mid-operation (`rst_n`=0 sampled in any state):
  - Next state is IDLE and `last`=1.
  - The in-flight op is discarded and no response is issued for it.
  - Requesters must re-present it.

## Timing
- Reset values:
  - `req0_ready`=0, `req1_ready`=0 (forced low while `rst_n`=0).
  - `alu_a`=0, `alu_b`=0, `alu_op`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_zero`=0.
- Accept in cycle T:
  - `alu_*` are valid from T+1.
  - `rsp_valid` rises at T+2.
- With `rsp_ready` held high, `rsp_valid` is high for exactly one cycle, at T+2.
- Fastest next accept is T+3, so peak throughput is one operation per 3 cycles.
- Backpressure extends RESP indefinitely with no loss.
- A request that arrives while the FSM is in EXEC/RESP waits. It is arbitrated in the first IDLE cycle.

## Test plan
- Port 0: a=10, b=10, op=0; `rsp_ready`=1 → `req0_ready` high in cycle T; `rsp_valid` at T+2 with `rsp_id`=0, `rsp_result`=20, `rsp_zero`=0.
- Port 1: a=10, b=10, op=4 → `rsp_id`=1, `rsp_result`=0, `rsp_zero`=1.
- First tie after reset:
  - Stimulus: both ports valid. Port 0 op=1 (10,10), port 1 op=5 (10,10).
  - Response order: port 0 (result 10), then port 1 (result 10) accepted at T+3.
  - Follow-up: a second simultaneous pair must be served port 0 first (last=1 after port 1); a tie right after a port 0 grant must go to port 1.
- Backpressure: port 0 a=10, b=10, op=6 with `rsp_ready`=0 for 5 cycles → `rsp_result`=655360 held stable; port 1 valid throughout gets no `req1_ready` until the cycle after the `rsp_ready` handshake.
- Reset in EXEC: `rst_n`=0 for one cycle → all outputs return to reset values, no `rsp_valid` for the aborted op. Then port 1 a=10, b=10, op=2 → `rsp_result`=0, `rsp_zero`=1, `rsp_id`=1.
- Stability: while `req0_valid` is held and the FSM is busy, `req0_ready` stays 0 and `alu_*` are unchanged.
